lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 149 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// RV32I load/store unit controller: aligns byte/half/word accesses onto a 32-bit data memory.
// Define LSU_SPLIT_EN to split word-crossing accesses into two memory cycles; otherwise they are rejected.
module lsu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  output logic        ce,
  input  logic [31:0] drdata
);

`ifdef LSU_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, raw_q;
  logic [2:0]  f3_q;
  logic        load_q, err_q;

  function automatic logic [2:0] size_of(input logic [1:0] f);
    case (f)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] off, input logic [1:0] f);
    return ({2'b00, off} + {1'b0, size_of(f)}) > 4'd4;
  endfunction

  // Request decode, evaluated on the live inputs while IDLE.
  logic req_legal, req_bad;
  always_comb begin
    if (req_load) req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else          req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    req_bad = !req_legal || (crosses(req_addr[1:0], req_funct3[1:0]) && !SPLIT_EN);
  end

  // Lane mask and store data over an 8-lane (two-word) window; ACC0 uses the low half, ACC1 the high.
  logic [1:0]  off_q;
  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] wide_wdata;
  logic [2:0]  acc0_bytes;
  logic        cross_q;
  always_comb begin
    off_q      = addr_q[1:0];
    case (f3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_mask  = {4'b0000, size_mask} << off_q;
    wide_wdata = {32'd0, wdata_q} << {off_q, 3'b000};
    acc0_bytes = 3'd4 - {1'b0, off_q};
    cross_q    = crosses(off_q, f3_q[1:0]);
  end

  logic [31:0] ext_rdata;
  always_comb begin
    case (f3_q)
      3'b000:  ext_rdata = {{24{raw_q[7]}}, raw_q[7:0]};
      3'b001:  ext_rdata = {{16{raw_q[15]}}, raw_q[15:0]};
      3'b100:  ext_rdata = {24'd0, raw_q[7:0]};
      3'b101:  ext_rdata = {16'd0, raw_q[15:0]};
      default: ext_rdata = raw_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: datapath registers carry no reset; they are only observed after being loaded on acceptance.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid && !reset) begin
      addr_q  <= req_addr;
      f3_q    <= req_funct3;
      load_q  <= req_load;
      wdata_q <= req_wdata;
      err_q   <= req_bad;
    end
    if (state == ACC0)      raw_q <= drdata >> {off_q, 3'b000};
    else if (state == ACC1) raw_q <= raw_q | (drdata << {acc0_bytes, 3'b000});
  end

  // NOTE: every output is given a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    ce         = 1'b0;
    we         = 4'b0000;
    daddr      = 32'd0;
    dwdata     = 32'd0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_bad ? RESP : ACC0;
      end
      ACC0: begin
        ce    = 1'b1;
        daddr = {addr_q[31:2], 2'b00};
        if (!load_q) begin
          we     = lane_mask[3:0];
          dwdata = wide_wdata[31:0];
        end
        state_nxt = (SPLIT_EN && cross_q) ? ACC1 : RESP;
      end
      ACC1: begin
        ce    = 1'b1;
        daddr = {addr_q[31:2], 2'b00} + 32'd4;
        if (!load_q) begin
          we     = lane_mask[7:4];
          dwdata = wide_wdata[63:32];
        end
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (load_q && !err_q) ? ext_rdata : 32'd0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl against a small byte-lane memory model.
// Crossing-access expectations follow whether LSU_SPLIT_EN is defined for the build.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, resp_rdata, daddr, dwdata, drdata;
  logic        resp_valid, resp_err, ce;
  logic [3:0]  we;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [64];

  lsu_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .daddr(daddr), .dwdata(dwdata), .we(we), .ce(ce), .drdata(drdata)
  );

  always #5 clk = ~clk;

  assign drdata = mem[daddr[7:2]];

  always @(posedge clk)
    if (ce)
      for (int n = 0; n < 4; n++)
        if (we[n]) mem[daddr[7:2]][8*n +: 8] <= dwdata[8*n +: 8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int          n_acc, lat;
  logic        got_resp;
  logic [31:0] acc_addr [4];
  logic [31:0] acc_dw   [4];
  logic [3:0]  acc_we   [4];
  logic [31:0] r_rdata;
  logic        r_err;

  // Issue one request and record every access cycle plus the response.
  task automatic txn(input string tag, input logic ld, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    n_acc = 0; lat = 0; got_resp = 1'b0; r_rdata = '0; r_err = 1'b0;
    for (int c = 1; c <= 8 && !got_resp; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (ce && n_acc < 4) begin
        acc_addr[n_acc] = daddr; acc_we[n_acc] = we; acc_dw[n_acc] = dwdata;
        n_acc++;
      end
      if (resp_valid) begin
        got_resp = 1'b1; lat = c; r_rdata = resp_rdata; r_err = resp_err;
      end
    end
    check({tag, ":resp_seen"}, got_resp, 1);
    @(negedge clk);
    check({tag, ":after_resp"}, {resp_valid, resp_err, resp_rdata}, 0);
  endtask

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset = 1'b1; req_valid = 1'b1; req_load = 1'b0; req_funct3 = W;
    req_addr = 32'h40; req_wdata = 32'h5555_5555;

    // Reset held with a simultaneous request: nothing accepted, all outputs idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset:ready", req_ready, 1);
    check("reset:outs", {resp_valid, resp_err, resp_rdata, daddr, dwdata, we, ce}, 0);
    req_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("reset:no_accept", {req_ready, ce}, 2'b10);
    check("reset:mem_untouched", mem[16], 0);

    txn("sw10", 0, W, 32'h10, 32'hDEAD_BEEF);
    check("sw10:lat", lat, 2);
    check("sw10:nacc", n_acc, 1);
    check("sw10:acc", {acc_addr[0], acc_we[0], acc_dw[0]}, {32'h10, 4'b1111, 32'hDEAD_BEEF});
    check("sw10:resp", {r_err, r_rdata}, 0);

    txn("sb13", 0, B, 32'h13, 32'h0000_00A5);
    check("sb13:we", acc_we[0], 4'b1000);
    check("sb13:dw_hi", acc_dw[0][31:24], 8'hA5);
    check("sb13:mem", mem[4], 32'hA5AD_BEEF);

    txn("lb13", 1, B, 32'h13, 32'h0);
    check("lb13:rdata", r_rdata, 32'hFFFF_FFA5);
    check("lb13:we", {acc_we[0], lat, r_err}, {4'b0000, 32'd2, 1'b0});
    txn("lbu13", 1, BU, 32'h13, 32'h0);
    check("lbu13:rdata", r_rdata, 32'h0000_00A5);

    txn("sw10b", 0, W, 32'h10, 32'h8899_AABB);
    txn("lh11", 1, H, 32'h11, 32'h0);
    check("lh11:rdata", r_rdata, 32'hFFFF_99AA);
    check("lh11:single", {n_acc, lat}, {32'd1, 32'd2});
    txn("lhu11", 1, HU, 32'h11, 32'h0);
    check("lhu11:rdata", r_rdata, 32'h0000_99AA);
    txn("lw10", 1, W, 32'h10, 32'h0);
    check("lw10:rdata", r_rdata, 32'h8899_AABB);

    txn("sw04", 0, W, 32'h04, 32'h4433_2211);
    txn("sw08", 0, W, 32'h08, 32'h8877_6655);
    txn("lw06", 1, W, 32'h06, 32'h0);
`ifdef LSU_SPLIT_EN
    check("lw06:lat", lat, 3);
    check("lw06:addrs", {n_acc, acc_addr[0], acc_addr[1]}, {32'd2, 32'h04, 32'h08});
    check("lw06:rdata", {r_err, r_rdata}, {1'b0, 32'h6655_4433});
`else
    check("lw06:lat", lat, 1);
    check("lw06:no_ce", n_acc, 0);
    check("lw06:err", {r_err, r_rdata}, {1'b1, 32'h0});
`endif

    txn("sw0e", 0, W, 32'h0E, 32'hCAFE_F00D);
`ifdef LSU_SPLIT_EN
    check("sw0e:acc0", {acc_addr[0], acc_we[0], acc_dw[0][31:16]}, {32'h0C, 4'b1100, 16'hF00D});
    check("sw0e:acc1", {acc_addr[1], acc_we[1], acc_dw[1][15:0]}, {32'h10, 4'b0011, 16'hCAFE});
    check("sw0e:mem", {mem[3], mem[4]}, {32'hF00D_0000, 32'h8899_CAFE});
`else
    check("sw0e:err", {r_err, n_acc, lat}, {1'b1, 32'd0, 32'd1});
`endif

    txn("ld011", 1, 3'b011, 32'h10, 32'h0);
    check("ld011:err", {r_err, r_rdata}, {1'b1, 32'h0});
    check("ld011:no_ce", {n_acc, lat}, {32'd0, 32'd1});
    txn("sd100", 0, 3'b100, 32'h20, 32'h1234_5678);
    check("sd100:err", {r_err, n_acc, mem[8]}, {1'b1, 32'd0, 32'h0});

    // A request held high while busy must be dropped, not queued.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_funct3 = W; req_addr = 32'h20; req_wdata = 32'h1111_1111;
    @(negedge clk);
    req_addr = 32'h24; req_wdata = 32'h2222_2222;
    @(negedge clk);
    check("busy:resp", resp_valid, 1);
    req_valid = 1'b0;
    @(negedge clk);
    check("busy:idle", {req_ready, ce}, 2'b10);
    check("busy:mem", {mem[8], mem[9]}, {32'h1111_1111, 32'h0});

    // Reset pulsed during ACC0 aborts the access.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_funct3 = W;
`ifdef LSU_SPLIT_EN
    req_addr = 32'h0E; req_wdata = 32'hCAFE_F00D;
`else
    req_addr = 32'h30; req_wdata = 32'h1234_5678;
`endif
    @(negedge clk);
    req_valid = 1'b0;
    check("abort:in_acc0", {ce, req_ready}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort:outs", {we, ce, resp_valid}, 0);
    check("abort:ready", req_ready, 1);
    n_acc = 0; lat = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ce) n_acc++;
      if (resp_valid) lat++;
    end
    check("abort:quiet", {n_acc, lat}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
